// File: rtl/ccd_pkg.sv
// Shared definitions for the linear-CCD line sequencer.
//   state_t  : sequencer FSM states
//   DEF_*    : default parameter values (1 MHz pixel clock from 50 MHz, 128 px)
//   bus_w()  : width of the packed multi-channel ADC bus
package ccd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SI_SETUP,
        SHIFT
    } state_t;

    localparam int DEF_CLK_DIV = 25;
    localparam int DEF_NPIX    = 128;
    localparam int DEF_NCH     = 1;
    localparam int DEF_ADC_W   = 8;
    localparam int DEF_ADC_LAT = 1;
    localparam int DEF_EXP_W   = 25;

    function automatic int bus_w(input int nch, input int adc_w);
        return nch * adc_w;
    endfunction

endpackage

// File: rtl/ccd_clk_gen.sv
// Pixel / ADC clock generator.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   div_cnt    : half-period divider count, owned by the sequencer
//   run        : high while a line is in progress
//   ccd_clk    : sensor pixel clock (low when idle)
//   adc_clk    : ADC clock, complement of ccd_clk while running, high when idle
//   rise, fall : single-cycle strobes, high in the first cycle of the new ccd_clk level
module ccd_clk_gen
    import ccd_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int DW      = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] div_cnt,
    input  logic          run,
    output logic          ccd_clk,
    output logic          adc_clk,
    output logic          rise,
    output logic          fall
);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic tick;
    assign tick = run && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccd_clk <= 1'b0;
            adc_clk <= 1'b1;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else if (!run) begin
            ccd_clk <= 1'b0;
            adc_clk <= 1'b1;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            // Strobes are registered with the clock so they line up with the
            // first cycle in which the new level is visible on the pin.
            rise <= tick && !ccd_clk;
            fall <= tick && ccd_clk;
            if (tick) begin
                ccd_clk <= !ccd_clk;
                adc_clk <= ccd_clk;
            end
        end
    end

endmodule

// File: rtl/ccd_line_sequencer.sv
// Linear-CCD (TSL1401-class) readout sequencer.
// Generates SI / pixel clock / ADC clock, times exposure, captures NCH ADC
// channels and writes pixels to a line FIFO with SOL/EOL markers.
// Ports:
//   clk, rst_n          : system clock, async active-low reset
//   en, mode, trig      : enable, 0 = single-shot on trig / 1 = continuous, line request
//   exp_cfg             : exposure period (SI start to SI start), latched at line start
//   adc_din             : NCH packed ADC samples
//   sink_full, clr_err  : FIFO back-pressure, sticky flag clear
//   si, ccd_clk, adc_clk: sensor / ADC timing outputs
//   out_valid/data/sol/eol : pixel write strobe, data, line markers
//   busy                : line in progress
//   ovf, exp_short, trig_miss : sticky error flags
module ccd_line_sequencer
    import ccd_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int NPIX    = DEF_NPIX,
    parameter int NCH     = DEF_NCH,
    parameter int ADC_W   = DEF_ADC_W,
    parameter int ADC_LAT = DEF_ADC_LAT,
    parameter int EXP_W   = DEF_EXP_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic                             mode,
    input  logic                             trig,
    input  logic [EXP_W-1:0]                 exp_cfg,
    input  logic [bus_w(NCH, ADC_W)-1:0]     adc_din,
    input  logic                             sink_full,
    input  logic                             clr_err,
    output logic                             si,
    output logic                             ccd_clk,
    output logic                             adc_clk,
    output logic                             out_valid,
    output logic [bus_w(NCH, ADC_W)-1:0]     out_data,
    output logic                             out_sol,
    output logic                             out_eol,
    output logic                             busy,
    output logic                             ovf,
    output logic                             exp_short,
    output logic                             trig_miss
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int FW = $clog2(NPIX + ADC_LAT + 1);
    localparam logic [DW-1:0]  DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [FW-1:0]  LAT_F     = FW'(ADC_LAT);
    localparam logic [FW-1:0]  FALL_LAST = FW'(NPIX + ADC_LAT - 1);
    localparam logic [EXP_W:0] EXP_ONE   = (EXP_W + 1)'(1);

    state_t           state;
    logic [DW-1:0]    div_cnt;
    logic [FW-1:0]    fall_cnt;     // falling edges seen so far this line
    logic [EXP_W-1:0] exp_cnt;
    logic [EXP_W-1:0] exp_lat;
    logic             cont_armed;   // a continuous line already ran since en/mode went high
    logic             run, rise, fall;
    logic [EXP_W:0]   exp_next;
    logic             exp_due, exp_late, start_ct, start, emit;

    assign run = (state != IDLE);

    ccd_clk_gen #(.CLK_DIV(CLK_DIV), .DW(DW)) u_clk_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_cnt (div_cnt),
        .run     (run),
        .ccd_clk (ccd_clk),
        .adc_clk (adc_clk),
        .rise    (rise),
        .fall    (fall)
    );

    always_comb begin
        // One extra bit so exp_lat of 0 compares as "already due".
        exp_next = {1'b0, exp_cnt} + EXP_ONE;
        exp_due  = exp_next >= {1'b0, exp_lat};
        exp_late = exp_next >  {1'b0, exp_lat};
        start_ct = en && mode && (!cont_armed || exp_due);
        start    = (state == IDLE) && ((en && !mode && trig) || start_ct);
        // Falling edge j samples pixel j-1-ADC_LAT; earlier edges flush the ADC pipe.
        emit     = (state == SHIFT) && fall && (fall_cnt >= LAT_F);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            si         <= 1'b0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_sol    <= 1'b0;
            out_eol    <= 1'b0;
            out_data   <= '0;
            div_cnt    <= '0;
            fall_cnt   <= '0;
            exp_cnt    <= '0;
            exp_lat    <= '0;
            cont_armed <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_sol   <= 1'b0;
            out_eol   <= 1'b0;
            div_cnt   <= (state == IDLE || div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);

            if (start)
                exp_cnt <= '0;
            else if (exp_cnt != '1)
                exp_cnt <= exp_cnt + EXP_W'(1);

            // A full sink drops the pixel; sequencing carries on regardless.
            if (emit) begin
                out_data  <= adc_din;
                out_valid <= !sink_full;
                out_sol   <= !sink_full && (fall_cnt == LAT_F);
                out_eol   <= !sink_full && (fall_cnt == FALL_LAST);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SI_SETUP;
                        si         <= 1'b1;
                        busy       <= 1'b1;
                        exp_lat    <= exp_cfg;
                        fall_cnt   <= '0;
                        cont_armed <= start_ct;
                    end else if (!(en && mode)) begin
                        cont_armed <= 1'b0;
                    end
                end
                SI_SETUP: begin
                    if (rise)
                        state <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST && ccd_clk)
                        si <= 1'b0;
                    if (fall) begin
                        fall_cnt <= fall_cnt + FW'(1);
                        if (fall_cnt == FALL_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf       <= 1'b0;
            exp_short <= 1'b0;
            trig_miss <= 1'b0;
        end else begin
            ovf       <= (emit && sink_full) || (ovf && !clr_err);
            exp_short <= (start && start_ct && cont_armed && exp_late) || (exp_short && !clr_err);
            trig_miss <= (trig && busy) || (trig_miss && !clr_err);
        end
    end

endmodule

// File: tb/tb_ccd_line_sequencer.sv
// Directed bench for ccd_line_sequencer (CLK_DIV=2, NPIX=8, NCH=2, ADC_W=8).
// A second instance with ADC_LAT=3 covers the longer ADC pipeline.
// Cycle n is the period following the n-th rising clock edge.
module tb_ccd_line_sequencer;

    localparam int EXP_W = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic en = 1'b0, en3 = 1'b0, mode = 1'b0, trig = 1'b0;
    logic sink_full = 1'b0, clr_err = 1'b0;
    logic [EXP_W-1:0] exp_cfg = '0;
    logic [15:0] adc_din = '0;

    logic si, ccd_clk, adc_clk, out_valid, out_sol, out_eol, busy, ovf, exp_short, trig_miss;
    logic [15:0] out_data;
    logic si3, ccd3, adc3, ov3, sol3, eol3, busy3, ovf3, es3, tm3;
    logic [15:0] dat3;

    int cyc = 0, errors = 0, checks = 0;

    ccd_line_sequencer #(.CLK_DIV(2), .NPIX(8), .NCH(2), .ADC_W(8), .ADC_LAT(1), .EXP_W(EXP_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .trig(trig), .exp_cfg(exp_cfg),
        .adc_din(adc_din), .sink_full(sink_full), .clr_err(clr_err),
        .si(si), .ccd_clk(ccd_clk), .adc_clk(adc_clk), .out_valid(out_valid), .out_data(out_data),
        .out_sol(out_sol), .out_eol(out_eol), .busy(busy), .ovf(ovf), .exp_short(exp_short),
        .trig_miss(trig_miss)
    );

    ccd_line_sequencer #(.CLK_DIV(2), .NPIX(8), .NCH(2), .ADC_W(8), .ADC_LAT(3), .EXP_W(EXP_W)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode), .trig(trig), .exp_cfg(exp_cfg),
        .adc_din(adc_din), .sink_full(sink_full), .clr_err(clr_err),
        .si(si3), .ccd_clk(ccd3), .adc_clk(adc3), .out_valid(ov3), .out_data(dat3),
        .out_sol(sol3), .out_eol(eol3), .busy(busy3), .ovf(ovf3), .exp_short(es3),
        .trig_miss(tm3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC sample value presented during cycle t
    function automatic logic [15:0] f(input int t);
        logic [7:0] b;
        b = t[7:0];
        return {b, b ^ 8'h5A};
    endfunction

    // Event recorders, sampled mid-cycle
    int si_rise_q[$], ccd_rise_q[$], v_cyc[$], c3_rise_q[$], v3_cyc[$];
    logic [15:0] v_dat[$], v3_dat[$];
    logic v_sol[$], v_eol[$], v3_eol[$];
    logic si_q = 1'b0, ccd_q = 1'b0, ccd3_q = 1'b0;

    always @(negedge clk) begin
        adc_din = f(cyc);
        if (si === 1'b1 && si_q === 1'b0) si_rise_q.push_back(cyc);
        if (ccd_clk === 1'b1 && ccd_q === 1'b0) ccd_rise_q.push_back(cyc);
        if (ccd3 === 1'b1 && ccd3_q === 1'b0) c3_rise_q.push_back(cyc);
        if (out_valid === 1'b1) begin
            v_cyc.push_back(cyc); v_dat.push_back(out_data);
            v_sol.push_back(out_sol); v_eol.push_back(out_eol);
        end
        if (ov3 === 1'b1) begin
            v3_cyc.push_back(cyc); v3_dat.push_back(dat3); v3_eol.push_back(eol3);
        end
        si_q = si; ccd_q = ccd_clk; ccd3_q = ccd3;
    end

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int bs, bv, bc, b3c, b3v;
        logic [7:0] solb, eolb;
        int sf_exp[6];
        sf_exp = '{530, 534, 538, 550, 554, 558};

        // reset state
        at(2);
        chk("reset_ctl", {si, ccd_clk, adc_clk, out_valid, out_sol, out_eol, busy, ovf, exp_short, trig_miss},
            10'b0010000000);
        chk("reset_data", out_data, 16'h0);
        at(3); rst_n = 1'b1;
        at(5); en = 1'b1;

        // single-shot line, trig in cycle 10
        bs = si_rise_q.size(); bv = v_cyc.size(); bc = ccd_rise_q.size();
        at(10); trig = 1'b1;
        at(11); trig = 1'b0;
        at(14); chk("ss_si_hi", si, 1);
        at(15); chk("ss_si_fall", si, 0);
        at(47); chk("ss_busy_last", busy, 1);
        at(48); chk("ss_idle", {busy, ccd_clk, adc_clk}, 3'b001);
        at(60);
        chk("ss_si_rise", si_rise_q[bs], 11);
        chk("ss_ccd_first", ccd_rise_q[bc], 13);
        chk("ss_ccd_periods", ccd_rise_q.size() - bc, 9);
        chk("ss_npix", v_cyc.size() - bv, 8);
        for (int p = 0; p < 8; p++) begin
            chk("ss_cyc", v_cyc[bv+p], 20 + 4*p);
            chk("ss_data", v_dat[bv+p], f(19 + 4*p));
            solb[p] = v_sol[bv+p];
            eolb[p] = v_eol[bv+p];
        end
        chk("ss_sol", solb, 8'h01);
        chk("ss_eol", eolb, 8'h80);

        // continuous, exposure 100 then 20
        bs = si_rise_q.size();
        at(70); mode = 1'b1; exp_cfg = 16'd100;
        at(300); exp_cfg = 16'd20;
        at(407); chk("ct_short_none", exp_short, 0);
        at(408); chk("ct_idle_gap", busy, 0);
        at(409); chk("ct_b2b", {busy, exp_short}, 2'b11);
        at(450); en = 1'b0;
        bv = v_cyc.size();
        at(498);
        chk("ct_si0", si_rise_q[bs], 71);
        chk("ct_per1", si_rise_q[bs+1] - si_rise_q[bs], 100);
        chk("ct_per2", si_rise_q[bs+2] - si_rise_q[bs+1], 100);
        chk("ct_si3", si_rise_q[bs+3], 371);
        chk("ct_si4", si_rise_q[bs+4], 409);
        chk("ct_si5", si_rise_q[bs+5], 447);
        chk("en_drop_lines", si_rise_q.size() - bs, 6);
        chk("en_drop_npix", v_cyc.size() - bv, 8);
        chk("en_drop_last", {v_cyc[bv+7], 31'd0, v_eol[bv+7]}, {484, 31'd0, 1'b1});
        chk("en_drop_idle", busy, 0);

        // clear flags, then sink_full over pixels 3-4
        at(500); clr_err = 1'b1;
        at(501); clr_err = 1'b0;
        at(502); chk("clr_flags", {ovf, exp_short, trig_miss}, 3'b000);
        at(505); mode = 1'b0; en = 1'b1;
        bv = v_cyc.size();
        at(520); trig = 1'b1;
        at(521); trig = 1'b0;
        at(541); chk("ovf_pre", ovf, 0); sink_full = 1'b1;
        at(543); chk("ovf_set", ovf, 1);
        at(547); sink_full = 1'b0;
        at(565);
        chk("sf_count", v_cyc.size() - bv, 6);
        for (int k = 0; k < 6; k++) chk("sf_cyc", v_cyc[bv+k], sf_exp[k]);
        chk("sf_sol", v_sol[bv], 1);
        chk("sf_eol", v_eol[bv+5], 1);
        chk("sf_data5", v_dat[bv+3], f(549));
        at(569); chk("ovf_sticky", ovf, 1);
        at(570); clr_err = 1'b1;
        at(571); clr_err = 1'b0;
        at(572); chk("ovf_clr", ovf, 0);

        // trig while busy
        bs = si_rise_q.size(); bv = v_cyc.size();
        at(600); trig = 1'b1;
        at(601); trig = 1'b0;
        at(605); chk("tm_pre", trig_miss, 0);
        at(610); trig = 1'b1;
        at(611); trig = 1'b0;
        at(612); chk("tm_set", trig_miss, 1);
        at(700);
        chk("tm_lines", si_rise_q.size() - bs, 1);
        chk("tm_npix", v_cyc.size() - bv, 8);

        // asynchronous reset in the middle of SHIFT
        at(720); trig = 1'b1;
        at(721); trig = 1'b0;
        at(724); chk("rst_pre", {si, ccd_clk, busy}, 3'b111);
        rst_n = 1'b0;
        #1;
        chk("rst_async", {si, ccd_clk, adc_clk, busy, out_valid}, 5'b00100);
        at(727); rst_n = 1'b1;
        chk("rst_flags", {ovf, exp_short, trig_miss}, 3'b000);
        bs = si_rise_q.size(); bv = v_cyc.size();
        at(740); trig = 1'b1;
        at(741); trig = 1'b0;
        at(790);
        chk("rs_si", si_rise_q[bs], 741);
        chk("rs_npix", v_cyc.size() - bv, 8);
        chk("rs_first", v_cyc[bv], 750);
        chk("rs_data", v_dat[bv], f(749));
        chk("rs_last", v_cyc[bv+7], 778);

        // ADC_LAT = 3 instance
        at(795); en3 = 1'b1;
        b3c = c3_rise_q.size(); b3v = v3_cyc.size();
        at(800); trig = 1'b1;
        at(801); trig = 1'b0;
        at(900);
        chk("lat3_periods", c3_rise_q.size() - b3c, 11);
        chk("lat3_npix", v3_cyc.size() - b3v, 8);
        chk("lat3_first", v3_cyc[b3v], 818);
        chk("lat3_data", v3_dat[b3v], f(817));
        chk("lat3_last", {v3_cyc[b3v+7], 31'd0, v3_eol[b3v+7]}, {846, 31'd0, 1'b1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
